// File: rtl/vga_game_pkg.sv
// Shared constants and types for the 1024x768 paddle-and-ball game.
// Contents: raster timing constants, game geometry, colour constants and
// the game_state encoding (SERVE=00, PLAY=01, MISS=10).
package vga_game_pkg;

  localparam int unsigned HPIXELS = 1344;
  localparam int unsigned VLINES  = 806;

  typedef logic [10:0] coord_t;

  localparam coord_t H_OFS      = 11'd297;
  localparam coord_t V_OFS      = 11'd36;
  localparam coord_t H_ACT      = 11'd1023;
  localparam coord_t V_ACT      = 11'd767;
  localparam coord_t BALL_SIZE  = 11'd16;
  localparam coord_t PAD_W      = 11'd128;
  localparam coord_t PAD_H      = 11'd16;
  localparam coord_t PAD_Y      = 11'd720;
  localparam coord_t BALL_SPEED = 11'd4;
  localparam coord_t PAD_SPEED  = 11'd8;
  localparam coord_t BORDER_W   = 11'd4;

  localparam logic [7:0] MISS_FRAMES = 8'd60;

  localparam coord_t BALL_X0   = (H_ACT - BALL_SIZE) >> 1;
  localparam coord_t BALL_Y0   = 11'd64;
  localparam coord_t PAD_X_MAX = H_ACT - PAD_W;
  localparam coord_t PAD_X0    = PAD_X_MAX >> 1;

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_WHITE  = 12'hFFF;
  localparam logic [11:0] COL_RED    = 12'hF00;
  localparam logic [11:0] COL_GREEN  = 12'h0F0;
  localparam logic [11:0] COL_BLUE   = 12'h00F;
  localparam logic [11:0] COL_YELLOW = 12'hFF0;

  typedef enum logic [1:0] {
    ST_SERVE = 2'b00,
    ST_PLAY  = 2'b01,
    ST_MISS  = 2'b10
  } game_state_e;

endpackage

// File: rtl/game_pixel_gen_ball_physics.sv
// ball_physics: game FSM, ball position/direction, score and miss counter.
// Ports: clk/clear (sync, active-high), frame_tick (once per frame),
// btn_any (either button), pad_x (paddle left edge), ball_x/ball_y,
// score (saturating hit count), state (SERVE/PLAY/MISS).
module ball_physics
  import vga_game_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        frame_tick,
  input  logic        btn_any,
  input  coord_t      pad_x,
  output coord_t      ball_x,
  output coord_t      ball_y,
  output logic [7:0]  score,
  output game_state_e state
);

  game_state_e state_q, state_d;
  coord_t      ball_x_q, ball_x_d;
  coord_t      ball_y_q, ball_y_d;
  logic        dx_right_q, dx_right_d;
  logic        dy_down_q, dy_down_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  miss_cnt_q, miss_cnt_d;
  coord_t      bot_now, bot_next;
  logic        pad_overlap;

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_right_d  = dx_right_q;
    dy_down_d   = dy_down_q;
    score_d     = score_q;
    miss_cnt_d  = miss_cnt_q;
    bot_now     = ball_y_q + BALL_SIZE;
    bot_next    = ball_y_q + BALL_SIZE + BALL_SPEED;
    pad_overlap = (ball_x_q + BALL_SIZE > pad_x) && (ball_x_q < pad_x + PAD_W);

    if (frame_tick) begin
      case (state_q)
        ST_SERVE: begin
          ball_x_d   = BALL_X0;
          ball_y_d   = BALL_Y0;
          dx_right_d = 1'b1;
          dy_down_d  = 1'b1;
          if (btn_any) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (dx_right_q) begin
            if (ball_x_q + BALL_SIZE + BALL_SPEED > H_ACT) begin
              ball_x_d   = H_ACT - BALL_SIZE;
              dx_right_d = 1'b0;
            end else begin
              ball_x_d = ball_x_q + BALL_SPEED;
            end
          end else begin
            if (ball_x_q < BALL_SPEED) begin
              ball_x_d   = '0;
              dx_right_d = 1'b1;
            end else begin
              ball_x_d = ball_x_q - BALL_SPEED;
            end
          end

          if (!dy_down_q) begin
            if (ball_y_q < BALL_SPEED) begin
              ball_y_d  = '0;
              dy_down_d = 1'b1;
            end else begin
              ball_y_d = ball_y_q - BALL_SPEED;
            end
          end else if (bot_now <= PAD_Y && bot_next >= PAD_Y && pad_overlap) begin
            ball_y_d  = PAD_Y - BALL_SIZE;
            dy_down_d = 1'b0;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end else if (bot_next >= V_ACT) begin
            // Floor miss freezes the ball: discard the X step resolved above.
            state_d    = ST_MISS;
            score_d    = '0;
            miss_cnt_d = '0;
            ball_x_d   = ball_x_q;
            dx_right_d = dx_right_q;
          end else begin
            ball_y_d = ball_y_q + BALL_SPEED;
          end
        end
        ST_MISS: begin
          if (miss_cnt_q == MISS_FRAMES - 8'd1) begin
            state_d    = ST_SERVE;
            miss_cnt_d = '0;
            ball_x_d   = BALL_X0;
            ball_y_d   = BALL_Y0;
            dx_right_d = 1'b1;
            dy_down_d  = 1'b1;
          end else begin
            miss_cnt_d = miss_cnt_q + 8'd1;
          end
        end
        default: state_d = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= ST_SERVE;
      ball_x_q   <= BALL_X0;
      ball_y_q   <= BALL_Y0;
      dx_right_q <= 1'b1;
      dy_down_q  <= 1'b1;
      score_q    <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      dx_right_q <= dx_right_d;
      dy_down_q  <= dy_down_d;
      score_q    <= score_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign ball_x = ball_x_q;
  assign ball_y = ball_y_q;
  assign score  = score_q;
  assign state  = state_q;

endmodule

// File: rtl/game_pixel_gen.sv
// game_pixel_gen: paddle-and-ball game renderer behind a 1024x768@65MHz
// VGA timing generator. Holds the paddle, the pixel colour mux and the
// one-clock sync delay; ball/score/FSM live in ball_physics.
// Ports: clk_65M, clear (sync, active-high), H_count/V_count/Vid_on/
// H_sync/V_sync from the timing generator, btn_left/btn_right (level),
// RGB (registered 12-bit), H_sync_out/V_sync_out (1-clock delayed),
// score, game_state.
// Build option: define SCORE_BAR_EN to draw a yellow score bar.
module game_pixel_gen
  import vga_game_pkg::*;
(
  input  logic        clk_65M,
  input  logic        clear,
  input  logic [16:0] H_count,
  input  logic [16:0] V_count,
  input  logic        Vid_on,
  input  logic        H_sync,
  input  logic        V_sync,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [11:0] RGB,
  output logic        H_sync_out,
  output logic        V_sync_out,
  output logic [7:0]  score,
  output logic [1:0]  game_state
);

  logic        frame_tick;
  coord_t      pad_x_q, pad_x_d, pad_room;
  coord_t      ball_x, ball_y;
  game_state_e state;
  coord_t      px, py;
  logic        in_ball, in_pad, in_border;
  logic [11:0] rgb_q, rgb_d;
  logic        h_sync_q, v_sync_q;

  assign frame_tick = (H_count == 17'(HPIXELS - 1)) && (V_count == 17'(VLINES - 1));

  always_comb begin
    pad_room = PAD_X_MAX - pad_x_q;
    pad_x_d  = pad_x_q;
    if (frame_tick) begin
      if (btn_left && !btn_right) begin
        pad_x_d = pad_x_q - ((pad_x_q < PAD_SPEED) ? pad_x_q : PAD_SPEED);
      end else if (btn_right && !btn_left) begin
        pad_x_d = pad_x_q + ((pad_room < PAD_SPEED) ? pad_room : PAD_SPEED);
      end
    end
  end

  ball_physics u_phys (
    .clk        (clk_65M),
    .clear      (clear),
    .frame_tick (frame_tick),
    .btn_any    (btn_left | btn_right),
    .pad_x      (pad_x_q),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score      (score),
    .state      (state)
  );

  // Wrapping 11-bit subtraction: blanking positions map to large values.
  assign px = H_count[10:0] - H_OFS;
  assign py = V_count[10:0] - V_OFS;

  assign in_ball   = (px >= ball_x) && (px < ball_x + BALL_SIZE) &&
                     (py >= ball_y) && (py < ball_y + BALL_SIZE);
  assign in_pad    = (px >= pad_x_q) && (px < pad_x_q + PAD_W) &&
                     (py >= PAD_Y) && (py < PAD_Y + PAD_H);
  assign in_border = (px < BORDER_W) || (px >= H_ACT - BORDER_W) || (py < BORDER_W);

`ifdef SCORE_BAR_EN
  logic in_bar;
  assign in_bar = (py >= 11'd8) && (py < 11'd16) &&
                  ({1'b0, px} >= 12'd8) &&
                  ({1'b0, px} < 12'd8 + {2'b00, score, 2'b00});
`endif

  always_comb begin
    rgb_d = COL_BLACK;
    if (!Vid_on) begin
      rgb_d = COL_BLACK;
    end else if (in_ball) begin
      rgb_d = (state == ST_MISS) ? COL_RED : COL_WHITE;
`ifdef SCORE_BAR_EN
    end else if (in_bar) begin
      rgb_d = COL_YELLOW;
`endif
    end else if (in_pad) begin
      rgb_d = COL_GREEN;
    end else if (in_border) begin
      rgb_d = COL_BLUE;
    end
  end

  always_ff @(posedge clk_65M) begin
    if (clear) begin
      pad_x_q  <= PAD_X0;
      rgb_q    <= '0;
      h_sync_q <= 1'b1;
      v_sync_q <= 1'b1;
    end else begin
      pad_x_q  <= pad_x_d;
      rgb_q    <= rgb_d;
      h_sync_q <= H_sync;
      v_sync_q <= V_sync;
    end
  end

  assign RGB        = rgb_q;
  assign H_sync_out = h_sync_q;
  assign V_sync_out = v_sync_q;
  assign game_state = state;

endmodule

// File: tb/tb_game_pixel_gen.sv
module tb_game_pixel_gen;

  logic        clk_65M = 1'b0;
  logic        clear;
  logic [16:0] H_count, V_count;
  logic        Vid_on, H_sync, V_sync, btn_left, btn_right;
  logic [11:0] RGB;
  logic        H_sync_out, V_sync_out;
  logic [7:0]  score;
  logic [1:0]  game_state;

  always #5 clk_65M = ~clk_65M;

  game_pixel_gen dut (
    .clk_65M    (clk_65M),
    .clear      (clear),
    .H_count    (H_count),
    .V_count    (V_count),
    .Vid_on     (Vid_on),
    .H_sync     (H_sync),
    .V_sync     (V_sync),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .RGB        (RGB),
    .H_sync_out (H_sync_out),
    .V_sync_out (V_sync_out),
    .score      (score),
    .game_state (game_state)
  );

  typedef enum int {K_RGB, K_HS, K_VS, K_SCORE, K_STATE, K_PADX, K_BX, K_BY, K_DXR, K_DYD} kind_e;
  typedef struct {
    int    cyc;
    kind_e kind;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk_65M) cyc <= cyc + 1;

  function automatic int actual(input kind_e k);
    case (k)
      K_RGB:   return int'(RGB);
      K_HS:    return int'(H_sync_out);
      K_VS:    return int'(V_sync_out);
      K_SCORE: return int'(score);
      K_STATE: return int'(game_state);
      K_PADX:  return int'(dut.pad_x_q);
      K_BX:    return int'(dut.u_phys.ball_x_q);
      K_BY:    return int'(dut.u_phys.ball_y_q);
      K_DXR:   return int'(dut.u_phys.dx_right_q);
      default: return int'(dut.u_phys.dy_down_q);
    endcase
  endfunction

  // Monitor: every clock the DUT presents registered outputs; compare all
  // expectations queued for this cycle.
  always @(negedge clk_65M) begin
    exp_t e;
    int   a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = actual(e.kind);
      n_tests++;
      if (e.cyc != cyc || a != e.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                 e.name, a, a, e.exp, e.exp, cyc);
      end
    end
  end

  task automatic push(input kind_e k, input int v, input string nm);
    exp_t e;
    e.cyc  = cyc + 1;
    e.kind = k;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drive(input logic clr, input int h, input int v, input logic vid,
                       input logic hs, input logic vs, input logic bl, input logic br,
                       input int exp_rgb, input string tag);
    @(posedge clk_65M);
    #1;
    clear     = clr;
    H_count   = 17'(h);
    V_count   = 17'(v);
    Vid_on    = vid;
    H_sync    = hs;
    V_sync    = vs;
    btn_left  = bl;
    btn_right = br;
    push(K_RGB, clr ? 0 : exp_rgb, {tag, "/rgb"});
    push(K_HS, clr ? 1 : int'(hs), {tag, "/h_sync_out"});
    push(K_VS, clr ? 1 : int'(vs), {tag, "/v_sync_out"});
  endtask

  task automatic tick(input logic bl, input logic br);
    drive(1'b0, 1343, 805, 1'b0, 1'b1, 1'b1, bl, br, 'h000, "tick");
  endtask

  task automatic exp_ball(input int x, input int y, input string tag);
    push(K_BX, x, {tag, "/ball_x"});
    push(K_BY, y, {tag, "/ball_y"});
  endtask

  task automatic exp_reset_state(input string tag);
    push(K_STATE, 0, {tag, "/state"});
    push(K_SCORE, 0, {tag, "/score"});
    push(K_PADX, 447, {tag, "/pad_x"});
    exp_ball(503, 64, tag);
    push(K_DXR, 1, {tag, "/dx_right"});
    push(K_DYD, 1, {tag, "/dy_down"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear = 1'b1; H_count = '0; V_count = '0; Vid_on = 1'b0;
    H_sync = 1'b1; V_sync = 1'b1; btn_left = 1'b0; btn_right = 1'b0;

    // Reset with syncs low: outputs must still come up high.
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 'h000, "reset");
    exp_reset_state("reset");

    // Static picture in SERVE; sync pattern checks the one-clock lag.
    drive(1'b0, 800, 100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 'hFFF, "ball_tl");
    drive(1'b0, 296, 100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 'h000, "blank");
    drive(1'b0, 300, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 'h00F, "border_x3");
    drive(1'b0, 301, 100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h000, "bg_x4");
    drive(1'b0, 815, 115, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 'hFFF, "ball_br");
    drive(1'b0, 816, 100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h000, "ball_rx");
    drive(1'b0, 800, 116, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h000, "ball_by");
    drive(1'b0, 1316, 100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h00F, "border_r");
    drive(1'b0, 1315, 100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h000, "bg_r");
    drive(1'b0, 797, 39, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h00F, "border_top");
    drive(1'b0, 744, 756, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h0F0, "pad_l");
    drive(1'b0, 743, 756, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h000, "pad_lx");
    drive(1'b0, 871, 771, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h0F0, "pad_br");
    drive(1'b0, 872, 756, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h000, "pad_rx");
    drive(1'b0, 800, 772, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h000, "pad_by");

    // btn_left held: first tick serves, paddle walks to 0 and stays there.
    for (int k = 1; k <= 60; k++) begin
      tick(1'b1, 1'b0);
      if (k == 1) begin
        push(K_STATE, 1, "serve/state");
        exp_ball(503, 64, "serve");
      end
      if (k == 2) exp_ball(507, 68, "first_move");
      if (k == 55) push(K_PADX, 7, "left55/pad_x");
      if (k == 56) push(K_PADX, 0, "left56/pad_x");
      if (k == 60) begin
        push(K_PADX, 0, "left60/pad_x");
        exp_ball(739, 300, "left60");
      end
    end

    // btn_right held: paddle saturates at 895, right wall and paddle hit.
    for (int j = 1; j <= 115; j++) begin
      tick(1'b0, 1'b1);
      if (j == 66) begin push(K_BX, 1003, "n125/ball_x"); push(K_DXR, 1, "n125/dx_right"); end
      if (j == 67) begin push(K_BX, 1007, "n126/ball_x"); push(K_DXR, 1, "n126/dx_right"); end
      if (j == 68) begin push(K_BX, 1007, "rwall/ball_x"); push(K_DXR, 0, "rwall/dx_right"); end
      if (j == 69) push(K_BX, 1003, "n128/ball_x");
      if (j == 100) begin
        exp_ball(879, 700, "prehit");
        push(K_SCORE, 0, "prehit/score");
        push(K_PADX, 800, "prehit/pad_x");
      end
      if (j == 101) begin
        push(K_BY, 704, "hit/ball_y");
        push(K_DYD, 0, "hit/dy_down");
        push(K_SCORE, 1, "hit/score");
      end
      if (j == 102) begin push(K_BY, 700, "posthit/ball_y"); push(K_SCORE, 1, "posthit/score"); end
      if (j == 111) push(K_PADX, 888, "right111/pad_x");
      if (j == 112) push(K_PADX, 895, "right112/pad_x");
      if (j == 115) begin
        push(K_PADX, 895, "right115/pad_x");
        exp_ball(819, 648, "right115");
      end
    end

    drive(1'b0, 1192, 756, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h0F0, "pad895");
    drive(1'b0, 1191, 756, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h000, "pad895_lx");
    drive(1'b0, 1116, 684, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'hFFF, "ball_play");

    // Idle: top wall, left wall, paddle missed, floor.
    for (int n = 175; n <= 525; n++) begin
      tick(1'b0, 1'b0);
      if (n == 335) push(K_BY, 4, "n335/ball_y");
      if (n == 336) begin push(K_BY, 0, "n336/ball_y"); push(K_DYD, 0, "n336/dy_down"); end
      if (n == 337) begin push(K_BY, 0, "twall/ball_y"); push(K_DYD, 1, "twall/dy_down"); end
      if (n == 338) push(K_BY, 4, "n338/ball_y");
      if (n == 378) begin push(K_BX, 3, "n378/ball_x"); push(K_DXR, 0, "n378/dx_right"); end
      if (n == 379) begin push(K_BX, 0, "lwall/ball_x"); push(K_DXR, 1, "lwall/dx_right"); end
      if (n == 380) push(K_BX, 4, "n380/ball_x");
      if (n == 512) exp_ball(532, 700, "n512");
      if (n == 513) begin
        push(K_BY, 704, "nohit/ball_y");
        push(K_DYD, 1, "nohit/dy_down");
        push(K_SCORE, 1, "nohit/score");
      end
      if (n == 524) begin
        exp_ball(580, 748, "n524");
        push(K_STATE, 1, "n524/state");
        push(K_SCORE, 1, "n524/score");
      end
      if (n == 525) begin
        exp_ball(580, 748, "miss");
        push(K_STATE, 2, "miss/state");
        push(K_SCORE, 0, "miss/score");
      end
    end

    drive(1'b0, 877, 784, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'hF00, "ball_red");
    drive(1'b0, 876, 784, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h000, "ball_red_lx");

    for (int r = 1; r <= 60; r++) begin
      tick(1'b0, 1'b0);
      if (r == 59) push(K_STATE, 2, "miss59/state");
      if (r == 60) begin
        push(K_STATE, 0, "reserve/state");
        exp_ball(503, 64, "reserve");
        push(K_DXR, 1, "reserve/dx_right");
        push(K_DYD, 1, "reserve/dy_down");
      end
    end
    drive(1'b0, 800, 100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'hFFF, "ball_white");

    tick(1'b0, 1'b1);
    push(K_STATE, 1, "serve2/state");
    push(K_PADX, 895, "serve2/pad_x");
    tick(1'b0, 1'b0);
    exp_ball(507, 68, "serve2_move");

    // Clear coinciding with frame_tick and a button: reset wins.
    drive(1'b1, 1343, 805, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h000, "clear_tick");
    exp_reset_state("clear_tick");
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 'h000, "idle");

    repeat (4) @(posedge clk_65M);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
